// File: rtl/hif_xbus_arb_pkg.sv
// Shared types and helpers for the host-interface xbus arbiter.
// Holds the FSM state type, default register-map limits and the access legality rule.
package hif_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  localparam logic [7:0] MAX_NOR_REG_ADDR_DEF  = 8'h64;
  localparam logic [7:0] MAX_TEST_REG_ADDR_DEF = 8'h65;

  // The address arrives already zero-extended to 8 bits.
  // Writes are additionally gated by OTP load completion.
  function automatic logic hif_legal(
    input logic [7:0] addr,
    input logic       wr,
    input logic       testmode_en,
    input logic       otp_done,
    input logic [7:0] max_nor  = MAX_NOR_REG_ADDR_DEF,
    input logic [7:0] max_test = MAX_TEST_REG_ADDR_DEF
  );
    logic [7:0] lim;
    lim = testmode_en ? max_test : max_nor;
    return (addr <= lim) && (!wr || otp_done);
  endfunction

endpackage

// File: rtl/hif_xbus_arb_if.sv
// Channel-side and xbus-side signal bundle for hif_xbus_arb.
// HIF_ARB_LOCK_EN adds the per-channel ch_lock request qualifier.
interface hif_xbus_arb_if #(
  parameter int unsigned NUM_CH          = 2,
  parameter int unsigned XBUS_ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH      = 8
);
  logic [NUM_CH-1:0]                 ch_req;
  logic [NUM_CH-1:0]                 ch_wr;
  logic [NUM_CH*XBUS_ADDR_WIDTH-1:0] ch_addr;
  logic [NUM_CH*DATA_WIDTH-1:0]      ch_din;
  logic [NUM_CH-1:0]                 ch_ack;
  logic                              ch_err;
  logic [DATA_WIDTH-1:0]             ch_dout;
  logic [XBUS_ADDR_WIDTH-1:0]        xbus_addr;
  logic                              xbus_wr;
  logic [DATA_WIDTH-1:0]             xbus_din;
  logic [DATA_WIDTH-1:0]             xbus_dout;
`ifdef HIF_ARB_LOCK_EN
  logic [NUM_CH-1:0]                 ch_lock;

  modport master (
    input  ch_req, ch_wr, ch_addr, ch_din, ch_lock, xbus_dout,
    output ch_ack, ch_err, ch_dout, xbus_addr, xbus_wr, xbus_din
  );
  modport slave (
    output ch_req, ch_wr, ch_addr, ch_din, ch_lock, xbus_dout,
    input  ch_ack, ch_err, ch_dout, xbus_addr, xbus_wr, xbus_din
  );
`else
  modport master (
    input  ch_req, ch_wr, ch_addr, ch_din, xbus_dout,
    output ch_ack, ch_err, ch_dout, xbus_addr, xbus_wr, xbus_din
  );
  modport slave (
    output ch_req, ch_wr, ch_addr, ch_din, xbus_dout,
    input  ch_ack, ch_err, ch_dout, xbus_addr, xbus_wr, xbus_din
  );
`endif
endinterface

// File: rtl/hif_xbus_arb_rr_pick.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module hif_rr_pick #(
  parameter  int unsigned NUM_CH = 2,
  localparam int unsigned CW     = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CW-1:0]     last_grant_i,
  output logic              valid_o,
  output logic [CW-1:0]     grant_o
);

  always_comb begin
    logic        found;
    int unsigned idx;
    found   = 1'b0;
    idx     = 0;
    grant_o = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      idx = (32'(last_grant_i) + k) % NUM_CH;
      if (!found && req_i[idx]) begin
        found   = 1'b1;
        grant_o = CW'(idx);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/hif_xbus_arb.sv
// Round-robin arbiter merging NUM_CH host channels onto one xbus register port.
// Optional HIF_ARB_LOCK_EN: a locked channel keeps the grant while it requests.
module hif_xbus_arb
  import hif_pkg::*;
#(
  parameter int unsigned NUM_CH            = 2,
  parameter int unsigned XBUS_ADDR_WIDTH   = 7,
  parameter int unsigned DATA_WIDTH        = 8,
  parameter logic [7:0]  MAX_NOR_REG_ADDR  = MAX_NOR_REG_ADDR_DEF,
  parameter logic [7:0]  MAX_TEST_REG_ADDR = MAX_TEST_REG_ADDR_DEF
) (
  input  logic           sys_clk,
  input  logic           rst_n,
  input  logic           otp_done,
  input  logic           testmode_en,
  output logic           hif_idle,
  hif_xbus_arb_if.master bus
);

  localparam int unsigned CW = $clog2(NUM_CH);
  localparam int unsigned AW = XBUS_ADDR_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;

  state_e          state_q, state_d;
  logic [CW-1:0]   grant_q, last_grant_q;
  logic [CW-1:0]   pick_grant, sel_grant;
  logic            pick_valid, arb_go;
  logic            wr_q, legal_q;
  logic [AW-1:0]   addr_q, sel_addr;
  logic [DW-1:0]   din_q, dout_q;

  hif_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
    .req_i       (bus.ch_req),
    .last_grant_i(last_grant_q),
    .valid_o     (pick_valid),
    .grant_o     (pick_grant)
  );

`ifdef HIF_ARB_LOCK_EN
  logic lock_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q <= 1'b0;
    end else if (state_q == DONE) begin
      lock_q <= bus.ch_lock[grant_q];
    end
  end

  // last_grant_q equals the locked channel once DONE has retired it.
  assign sel_grant = (lock_q && bus.ch_req[last_grant_q]) ? last_grant_q : pick_grant;
`else
  assign sel_grant = pick_grant;
`endif

  assign arb_go   = (state_q == IDLE) && pick_valid;
  assign sel_addr = bus.ch_addr[sel_grant*AW +: AW];

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_valid) state_d = ACCESS;
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q      <= '0;
      last_grant_q <= CW'(NUM_CH - 1);
      wr_q         <= 1'b0;
      legal_q      <= 1'b0;
      addr_q       <= '0;
      din_q        <= '0;
      dout_q       <= '0;
    end else begin
      if (arb_go) begin
        grant_q <= sel_grant;
        addr_q  <= sel_addr;
        din_q   <= bus.ch_din[sel_grant*DW +: DW];
        wr_q    <= bus.ch_wr[sel_grant];
        legal_q <= hif_legal(8'(sel_addr), bus.ch_wr[sel_grant], testmode_en, otp_done,
                             MAX_NOR_REG_ADDR, MAX_TEST_REG_ADDR);
      end
      if (state_q == ACCESS) begin
        dout_q <= (legal_q && !wr_q) ? bus.xbus_dout : '0;
      end
      if (state_q == DONE) begin
        last_grant_q <= grant_q;
      end
    end
  end

  always_comb begin
    bus.xbus_addr = addr_q;
    bus.xbus_din  = din_q;
    bus.xbus_wr   = (state_q == ACCESS) && legal_q && wr_q;
    bus.ch_ack    = '0;
    if (state_q == DONE) begin
      bus.ch_ack[grant_q] = 1'b1;
    end
    bus.ch_err  = (state_q == DONE) && !legal_q;
    bus.ch_dout = (state_q == DONE) ? dout_q : '0;
    hif_idle    = (state_q == IDLE) && !(|bus.ch_req);
  end

endmodule

// File: tb/tb_hif_xbus_arb.sv
// Self-checking bench for hif_xbus_arb: transaction-level model plus directed vectors.
module tb_hif_xbus_arb;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 7;
  localparam int unsigned DW = 8;

  logic sys_clk     = 1'b0;
  logic rst_n       = 1'b0;
  logic otp_done    = 1'b1;
  logic testmode_en = 1'b0;
  logic hif_idle;
  logic run_chk     = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  hif_xbus_arb_if #(.NUM_CH(N), .XBUS_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  hif_xbus_arb #(
    .NUM_CH           (N),
    .XBUS_ADDR_WIDTH  (AW),
    .DATA_WIDTH       (DW),
    .MAX_NOR_REG_ADDR (8'h64),
    .MAX_TEST_REG_ADDR(8'h65)
  ) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .otp_done   (otp_done),
    .testmode_en(testmode_en),
    .hif_idle   (hif_idle),
    .bus        (bus)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [7:0] init_val(input int i);
    if (i == 16) return 8'hA5;
    return 8'(i * 3 + 7);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Register file behind xbus: combinational read, write on strobe.
  logic [7:0] mem [128];
  assign bus.xbus_dout = mem[bus.xbus_addr];
  always @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 128; i++) mem[i] <= init_val(i);
    end else if (bus.xbus_wr) begin
      mem[bus.xbus_addr] <= bus.xbus_din;
    end
  end

  // Model: each grant schedules two cycles of expected outputs (strobe, then ack).
  typedef struct packed {
    logic       busy;
    logic       wr;
    logic [6:0] addr;
    logic [7:0] din;
    logic [1:0] ack;
    logic       err;
    logic [7:0] dout;
  } exp_t;

  exp_t       cur;
  exp_t       q[$];
  int         m_last;
  logic       m_lock;
  logic [7:0] mmem [128];

  always @(posedge sys_clk or negedge rst_n) begin : mdl
    exp_t       a, d;
    int         w;
    logic [6:0] ad;
    logic [7:0] dn, lim;
    logic       wrr, legal;
    if (!rst_n) begin
      q.delete();
      cur    = '0;
      m_last = N - 1;
      m_lock = 1'b0;
      for (int i = 0; i < 128; i++) mmem[i] = init_val(i);
    end else begin
`ifdef HIF_ARB_LOCK_EN
      if (cur.ack != 2'b00) m_lock = bus.ch_lock[m_last];
`endif
      if (cur.wr) mmem[cur.addr] = cur.din;
      if (!cur.busy && (|bus.ch_req)) begin
        w = -1;
        if (m_lock && bus.ch_req[m_last]) w = m_last;
        for (int k = 1; k <= N; k++) begin
          if (w < 0 && bus.ch_req[(m_last + k) % N]) w = (m_last + k) % N;
        end
        ad    = bus.ch_addr[w*AW +: AW];
        dn    = bus.ch_din[w*DW +: DW];
        wrr   = bus.ch_wr[w];
        lim   = testmode_en ? 8'h65 : 8'h64;
        legal = ({1'b0, ad} <= lim) && (!wrr || otp_done);
        a      = '0;
        a.busy = 1'b1;
        a.addr = ad;
        a.din  = dn;
        a.wr   = legal && wrr;
        d      = a;
        d.wr   = 1'b0;
        d.ack  = 2'(1 << w);
        d.err  = !legal;
        d.dout = (legal && !wrr) ? mmem[ad] : 8'h00;
        q.push_back(a);
        q.push_back(d);
        m_last = w;
      end
      if (q.size() > 0) begin
        cur = q.pop_front();
      end else begin
        cur.busy = 1'b0;
        cur.wr   = 1'b0;
        cur.ack  = 2'b00;
        cur.err  = 1'b0;
        cur.dout = 8'h00;
      end
    end
  end

  always @(negedge sys_clk) begin
    if (rst_n && run_chk) begin
      chk("m_ack",   bus.ch_ack,    cur.ack);
      chk("m_err",   bus.ch_err,    cur.err);
      chk("m_dout",  bus.ch_dout,   cur.dout);
      chk("m_wr",    bus.xbus_wr,   cur.wr);
      chk("m_addr",  bus.xbus_addr, cur.addr);
      chk("m_din",   bus.xbus_din,  cur.din);
      chk("m_idle",  hif_idle,      !cur.busy && !(|bus.ch_req));
    end
  end

  task automatic access(input int ch, input logic wr, input logic [6:0] addr,
                        input logic [7:0] din, output logic [7:0] dout, output logic err,
                        output int lat, output int nwr, output logic [6:0] wa,
                        output logic [7:0] wd);
    @(negedge sys_clk);
    #1;
    bus.ch_wr[ch]            = wr;
    bus.ch_addr[ch*AW +: AW] = addr;
    bus.ch_din[ch*DW +: DW]  = din;
    bus.ch_req[ch]           = 1'b1;
    lat = 0; nwr = 0; wa = '0; wd = '0; dout = '0; err = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge sys_clk);
      if (bus.xbus_wr) begin
        nwr++;
        wa = bus.xbus_addr;
        wd = bus.xbus_din;
      end
      if (bus.ch_ack[ch]) begin
        lat  = n;
        dout = bus.ch_dout;
        err  = bus.ch_err;
        break;
      end
    end
    #1 bus.ch_req[ch] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] dout, wd;
    logic       err;
    logic [6:0] wa;
    int         lat, nwr, cnt, nidle;
    logic [1:0] sq [4];
    int         tq [4];

    bus.ch_req  = '0;
    bus.ch_wr   = '0;
    bus.ch_addr = '0;
    bus.ch_din  = '0;
`ifdef HIF_ARB_LOCK_EN
    bus.ch_lock = '0;
`endif
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    #1 rst_n = 1'b1;
    run_chk = 1'b1;

    @(negedge sys_clk);
    chk("rst_ack",  bus.ch_ack,    0);
    chk("rst_err",  bus.ch_err,    0);
    chk("rst_dout", bus.ch_dout,   0);
    chk("rst_wr",   bus.xbus_wr,   0);
    chk("rst_addr", bus.xbus_addr, 0);
    chk("rst_din",  bus.xbus_din,  0);
    chk("rst_idle", hif_idle,      1);

    access(0, 1'b0, 7'h10, 8'h00, dout, err, lat, nwr, wa, wd);
    chk("rd_lat", lat, 2); chk("rd_data", dout, 8'hA5); chk("rd_err", err, 0); chk("rd_nwr", nwr, 0);

    access(1, 1'b1, 7'h64, 8'h3C, dout, err, lat, nwr, wa, wd);
    chk("wr_lat", lat, 2); chk("wr_nwr", nwr, 1); chk("wr_addr", wa, 7'h64);
    chk("wr_din", wd, 8'h3C); chk("wr_err", err, 0);
    access(0, 1'b0, 7'h64, 8'h00, dout, err, lat, nwr, wa, wd);
    chk("rdback", dout, 8'h3C);

    access(0, 1'b0, 7'h65, 8'h00, dout, err, lat, nwr, wa, wd);
    chk("t0_65_err", err, 1); chk("t0_65_dout", dout, 0);
    access(1, 1'b1, 7'h65, 8'h11, dout, err, lat, nwr, wa, wd);
    chk("t0_65w_err", err, 1); chk("t0_65w_nwr", nwr, 0);
    testmode_en = 1'b1;
    access(0, 1'b0, 7'h65, 8'h00, dout, err, lat, nwr, wa, wd);
    chk("t1_65_err", err, 0); chk("t1_65_dout", dout, 8'h36);
    access(1, 1'b0, 7'h66, 8'h00, dout, err, lat, nwr, wa, wd);
    chk("t1_66_err", err, 1);
    access(0, 1'b0, 7'h7F, 8'h00, dout, err, lat, nwr, wa, wd);
    chk("t1_7f_err", err, 1); chk("t1_7f_dout", dout, 0);
    testmode_en = 1'b0;

    otp_done = 1'b0;
    access(1, 1'b1, 7'h20, 8'h77, dout, err, lat, nwr, wa, wd);
    chk("otp_w_err", err, 1); chk("otp_w_nwr", nwr, 0);
    access(1, 1'b0, 7'h20, 8'h00, dout, err, lat, nwr, wa, wd);
    chk("otp_r_err", err, 0); chk("otp_r_dout", dout, 8'h67);
    otp_done = 1'b1;

    // Both channels requesting continuously from reset.
    do_reset();
    @(negedge sys_clk);
    #1;
    bus.ch_wr   = 2'b00;
    bus.ch_addr = {7'h64, 7'h10};
    bus.ch_req  = 2'b11;
    cnt = 0; nidle = 0;
    for (int n = 1; n <= 30 && cnt < 4; n++) begin
      @(negedge sys_clk);
      if (hif_idle) nidle++;
      if (bus.ch_ack != 2'b00) begin
        sq[cnt] = bus.ch_ack;
        tq[cnt] = n;
        cnt++;
      end
    end
    #1 bus.ch_req = 2'b00;
    chk("rr_cnt", cnt, 4);
    if (cnt == 4) begin
      chk("rr_seq0", sq[0], 2'b01); chk("rr_seq1", sq[1], 2'b10);
      chk("rr_seq2", sq[2], 2'b01); chk("rr_seq3", sq[3], 2'b10);
      chk("rr_t0", tq[0], 2);
      chk("rr_gap1", tq[1] - tq[0], 3); chk("rr_gap2", tq[2] - tq[1], 3);
      chk("rr_gap3", tq[3] - tq[2], 3);
    end
    chk("rr_busy", nidle, 0);

    // Reset while a legal write is on the bus: the write must not land.
    @(negedge sys_clk);
    #1;
    bus.ch_wr[0]        = 1'b1;
    bus.ch_addr[0 +: AW] = 7'h05;
    bus.ch_din[0 +: DW]  = 8'h99;
    bus.ch_req[0]       = 1'b1;
    @(posedge sys_clk);
    #1;
    chk("mid_wr", bus.xbus_wr, 1);
    chk("mid_addr", bus.xbus_addr, 7'h05);
    rst_n      = 1'b0;
    bus.ch_req = 2'b00;
    #1;
    chk("arst_wr",   bus.xbus_wr,   0);
    chk("arst_ack",  bus.ch_ack,    0);
    chk("arst_idle", hif_idle,      1);
    chk("arst_addr", bus.xbus_addr, 0);
    repeat (2) @(negedge sys_clk);
    #1 rst_n = 1'b1;
    access(0, 1'b0, 7'h05, 8'h00, dout, err, lat, nwr, wa, wd);
    chk("arst_nowrite", dout, 8'h16);

`ifdef HIF_ARB_LOCK_EN
    do_reset();
    @(negedge sys_clk);
    #1;
    bus.ch_wr      = 2'b00;
    bus.ch_addr    = {7'h20, 7'h10};
    bus.ch_lock[0] = 1'b1;
    bus.ch_req     = 2'b11;
    cnt = 0;
    for (int n = 1; n <= 40 && cnt < 4; n++) begin
      @(negedge sys_clk);
      if (bus.ch_ack != 2'b00) begin
        sq[cnt] = bus.ch_ack;
        cnt++;
        if (cnt == 3) #1 bus.ch_lock[0] = 1'b0;
      end
    end
    #1 bus.ch_req = 2'b00;
    chk("lk_cnt", cnt, 4);
    if (cnt == 4) begin
      chk("lk_a0", sq[0], 2'b01); chk("lk_a1", sq[1], 2'b01);
      chk("lk_a2", sq[2], 2'b01); chk("lk_a3", sq[3], 2'b10);
    end
`endif

    repeat (4) @(negedge sys_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
